// File: rtl/status_reg_bank.sv
// Status register bank: sticky hard errors, saturating soft-error counters with
// threshold flags, split-timestamp snapshot and live status words behind an IPbus port.
module status_reg_bank #(
    parameter int N_ERR     = 8,
    parameter int N_SOFT    = 3,
    parameter int CNT_WIDTH = 32,
    parameter int N_LIVE    = 12,
    parameter int TS_WIDTH  = 44
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_ERR-1:0]              err_in,
    input  logic [N_SOFT-1:0]             soft_evt,
    input  logic [N_SOFT*CNT_WIDTH-1:0]   soft_thres,
    input  logic [N_LIVE*32-1:0]          live_status,
    input  logic [TS_WIDTH-1:0]           ts_in,
    input  logic                          ipb_strobe,
    input  logic                          ipb_write,
    input  logic [7:0]                    ipb_addr,
    input  logic [31:0]                   ipb_wdata,
    output logic [31:0]                   ipb_rdata,
    output logic                          ipb_ack,
    output logic [N_ERR-1:0]              err_sticky,
    output logic [N_SOFT-1:0]             soft_error,
    output logic                          any_error
);

    localparam int SH_W = TS_WIDTH - 32;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 accept;
    logic                 is_wr;
    logic                 is_rd;
    logic [N_ERR-1:0]     err_clr;
    logic [N_SOFT-1:0]    soft_clr;
    logic [31:0]          rd_mux;
    logic [CNT_WIDTH-1:0] thres [N_SOFT];

    logic                 ack_d,    ack_q;
    logic [31:0]          rdata_d,  rdata_q;
    logic [N_ERR-1:0]     err_d,    err_q;
    logic [N_SOFT-1:0]    soft_d,   soft_q;
    logic [CNT_WIDTH-1:0] cnt_d [N_SOFT];
    logic [CNT_WIDTH-1:0] cnt_q [N_SOFT];
    logic [SH_W-1:0]      shadow_d, shadow_q;
    logic                 any_d,    any_q;

    always_comb begin
        accept   = ipb_strobe & ~ack_q;
        is_wr    = accept & ipb_write;
        is_rd    = accept & ~ipb_write;
        err_clr  = '0;
        soft_clr = '0;
        if (is_wr && ipb_addr == 8'h00) err_clr  = ipb_wdata[N_ERR-1:0];
        if (is_wr && ipb_addr == 8'h01) soft_clr = ipb_wdata[N_SOFT-1:0];
        for (int i = 0; i < N_SOFT; i++) begin
            thres[i] = soft_thres[i*CNT_WIDTH +: CNT_WIDTH];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (ipb_addr)
            8'h00:   rd_mux[N_ERR-1:0]  = err_q;
            8'h01:   rd_mux[N_SOFT-1:0] = soft_q;
            8'h02:   rd_mux             = ts_in[31:0];
            8'h03:   rd_mux[SH_W-1:0]   = shadow_q;
            default: ;
        endcase
        for (int i = 0; i < N_SOFT; i++) begin
            if (ipb_addr == (8'h10 | 8'(i))) rd_mux[CNT_WIDTH-1:0] = cnt_q[i];
            if (ipb_addr == (8'h20 | 8'(i))) rd_mux[CNT_WIDTH-1:0] = thres[i];
        end
        for (int j = 0; j < N_LIVE; j++) begin
            if (ipb_addr == (8'h40 + 8'(j))) rd_mux = live_status[j*32 +: 32];
        end
    end

    always_comb begin
        ack_d    = accept;
        rdata_d  = rdata_q;
        if (accept) rdata_d = ipb_write ? 32'h0 : rd_mux;
        // A new error in the same cycle as its W1C clear keeps the bit set.
        err_d    = (err_q & ~err_clr) | err_in;
        shadow_d = shadow_q;
        if (is_rd && ipb_addr == 8'h02) shadow_d = ts_in[TS_WIDTH-1:32];
        for (int i = 0; i < N_SOFT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (soft_clr[i]) begin
                cnt_d[i] = '0;
            end else if (soft_evt[i] && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
            soft_d[i] = soft_clr[i] ? 1'b0
                      : soft_q[i] | ((thres[i] != '0) && (cnt_q[i] >= thres[i]));
        end
        any_d = (|err_q) | (|soft_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= '0;
            soft_q   <= '0;
            shadow_q <= '0;
            any_q    <= 1'b0;
            for (int i = 0; i < N_SOFT; i++) cnt_q[i] <= '0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            soft_q   <= soft_d;
            shadow_q <= shadow_d;
            any_q    <= any_d;
            for (int i = 0; i < N_SOFT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign ipb_ack    = ack_q;
    assign ipb_rdata  = rdata_q;
    assign err_sticky = err_q;
    assign soft_error = soft_q;
    assign any_error  = any_q;

endmodule

// File: doc/status_reg_bank.md
Name: status_reg_bank

Overview:
- Parametrised successor to the fixed status register block; sits between the Rider status sources and the IPbus slave fabric.
- Adds a registered IPbus read/write port (fixed one-cycle ack).
- Adds sticky hard-error latching with write-1-to-clear.
- Adds saturating soft-error counters with programmable thresholds and latched soft-error flags.
- Adds a coherent snapshot of a wide timestamp split across two 32-bit words, plus N_LIVE pass-through status words.

Parameters:
N_ERR, 8, number of hard-error inputs (1..32)
N_SOFT, 3, number of soft-error event counters (1..16)
CNT_WIDTH, 32, soft counter width (8..32)
N_LIVE, 12, number of 32-bit live status words (1..32)
TS_WIDTH, 44, timestamp width (33..64)

Ports:
clk  in  1  user interface clock
reset  in  1  asynchronous active-high reset
err_in  in  N_ERR  raw hard-error levels/pulses, synchronous to clk
soft_evt  in  N_SOFT  one-cycle soft-error event pulses
soft_thres  in  N_SOFT*CNT_WIDTH  per-counter thresholds, index i at [i*CNT_WIDTH +: CNT_WIDTH]
live_status  in  N_LIVE*32  pass-through words, word j at [j*32 +: 32]
ts_in  in  TS_WIDTH  free-running trigger timestamp
ipb_strobe  in  1  bus transaction request
ipb_write  in  1  1 = write, 0 = read
ipb_addr  in  8  word address
ipb_wdata  in  32  write data
ipb_rdata  out  32  read data, valid while ipb_ack = 1
ipb_ack  out  1  one-cycle transaction acknowledge
err_sticky  out  N_ERR  latched hard errors
soft_error  out  N_SOFT  latched threshold-crossed flags
any_error  out  1  OR of err_sticky and soft_error

Behaviour:
- Reset (async assert, sync release): err_sticky, soft_error, all counters, ts shadow, ipb_ack, ipb_rdata, any_error = 0.
- Bus accept: accept when ipb_strobe=1 and ipb_ack=0. ipb_ack=1 exactly on the next cycle, for one cycle.
- Bus data: ipb_rdata is registered on accept; it holds its value until the next accept.
- Back-to-back: a strobe held high yields an ack every second cycle.
- Writes: ipb_rdata = 0. Writes to read-only addresses are acked and ignored.
- Address map, 0x00: err_sticky, zero-extended. Write-1-to-clear per bit.
- Address map, 0x01: soft_error, zero-extended. Writing 1 to bit i clears soft_error[i] and counter i.
- Address map, 0x02: ts_in[31:0] at accept. The same cycle copies ts_in[TS_WIDTH-1:32] into the shadow register.
- Address map, 0x03: shadow register, zero-extended. It changes only on a read of 0x02.
- Address map, 0x10+i (i < N_SOFT): counter i, zero-extended.
- Address map, 0x20+i (i < N_SOFT): soft_thres slice i, zero-extended.
- Address map, 0x40+j (j < N_LIVE): live_status word j, sampled at accept.
- Address map, other addresses: read 0x00000000, still acked.
- Sticky errors: err_sticky[k] <= err_sticky[k] | err_in[k] each cycle. If set and W1C clear hit the same bit in the same cycle, set wins (bit stays 1).
- Counters: increment by 1 on soft_evt[i] and saturate at 2^CNT_WIDTH-1 (no wrap). If an event and a clear of counter i occur in the same cycle, clear wins (result 0).
- Threshold: soft_error[i] is set on the cycle after counter i becomes >= soft_thres[i], when the threshold is non-zero. Threshold 0 disables flag setting. The flag stays latched until cleared, even if the threshold is raised afterwards.
- any_error: registered, so it lags err_sticky/soft_error by one cycle.
- Reset mid-transaction: ack suppressed, no state updated; the master retries.
- Read latency: 1 cycle from accept to ack and data.

Test Plan:
- Reset, then read 0x00, 0x01, 0x10 -> each acked 1 cycle after strobe, rdata = 0. any_error = 0.
- Pulse err_in[3] for 1 cycle; read 0x00 -> 0x00000008. Write 0x08 to 0x00 with err_in[3] held high -> reads 0x08. Write again with err_in[3] low -> reads 0.
- soft_thres[0]=3; pulse soft_evt[0] x3 -> 0x10 reads 3, soft_error[0]=1 one cycle later, any_error=1. Write 0x1 to 0x01 -> counter 0 = 0, flag = 0.
- Force counter width 8 (CNT_WIDTH=8), thres 0, 300 events -> 0x10 reads 0x000000FF, soft_error stays 0.
- ts_in=0x123_89ABCDEF: read 0x02 -> 0x89ABCDEF. Change ts_in to 0x456_00000000 and read 0x03 -> 0x00000123.
- live_status word 5 = 0xCAFEF00D: read 0x45 -> 0xCAFEF00D. Read 0x7F -> 0. Hold strobe high for 6 cycles -> exactly 3 ack pulses.
